ex_mem_alu_stage: RTL and testbench

Execute-stage datapath of the pipelined MIPS core. It consumes the 3-bit ALUControl code from the ALU control unit, applies operand forwarding and the ALUSrc immediate mux, and computes the ALU result. It then captures the result and the downstream control fields in the EX/MEM pipeline register. The register supports stall, flush and bubble (valid) handling.

---
 rtl/alu_pkg.sv | 17 +
 rtl/alu_core.sv | 62 ++++++
 rtl/ex_mem_alu_stage.sv | 141 ++++++++++++++
 tb/tb_ex_mem_alu_stage.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions for the execute stage: ALUControl operation codes
// and forwarding-source select codes used by the operand muxes.
package alu_pkg;

  // ALUControl operation codes (011, 100 and 101 are unused and give zero)
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // Forward-select codes (11 falls back to the register-file operand)
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU: AND, OR, ADD, SUB and signed SLT on WIDTH-bit operands.
// Produces the result, a zero flag and a signed-overflow flag that is only
// meaningful (non-zero) for ADD and SUB.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [2:0]       i_ctrl,
  output logic [WIDTH-1:0] o_result,
  output logic             o_zero,
  output logic             o_overflow
);

  logic signed [WIDTH-1:0] w_a_s;
  logic signed [WIDTH-1:0] w_b_s;
  logic signed [WIDTH-1:0] w_sum_s;
  logic signed [WIDTH-1:0] w_diff_s;
  logic                    w_ovf_add;
  logic                    w_ovf_sub;
  logic                    w_slt;

  assign w_a_s    = $signed(i_a);
  assign w_b_s    = $signed(i_b);
  assign w_sum_s  = w_a_s + w_b_s;
  assign w_diff_s = w_a_s - w_b_s;

  // Same-sign operands producing an opposite-sign sum overflow on ADD;
  // opposite-sign operands whose difference flips away from A overflow on SUB.
  assign w_ovf_add = (w_a_s[WIDTH-1] == w_b_s[WIDTH-1]) &&
                     (w_sum_s[WIDTH-1] != w_a_s[WIDTH-1]);
  assign w_ovf_sub = (w_a_s[WIDTH-1] != w_b_s[WIDTH-1]) &&
                     (w_diff_s[WIDTH-1] != w_a_s[WIDTH-1]);

  // Correcting the sign of A-B with its overflow keeps SLT exact over the full range
  assign w_slt = w_diff_s[WIDTH-1] ^ w_ovf_sub;

  // Operation select; unused codes return zero with no overflow
  always_comb begin
    o_result   = '0;
    o_overflow = 1'b0;
    case (i_ctrl)
      ALU_AND: o_result = i_a & i_b;
      ALU_OR:  o_result = i_a | i_b;
      ALU_ADD: begin
        o_result   = w_sum_s;
        o_overflow = w_ovf_add;
      end
      ALU_SUB: begin
        o_result   = w_diff_s;
        o_overflow = w_ovf_sub;
      end
      ALU_SLT: o_result = {{(WIDTH-1){1'b0}}, w_slt};
      default: o_result = '0;
    endcase
  end

  assign o_zero = (o_result == '0);

endmodule

// File: rtl/ex_mem_alu_stage.sv
// Execute stage of the pipelined MIPS core: operand forwarding, ALUSrc
// immediate mux, ALU, and the EX/MEM pipeline register with stall, flush
// and bubble handling.
// Optional feature macro EX_OVERFLOW_TRAP_EN: when defined, Overflow_M
// carries ADD/SUB signed overflow and an overflowing instruction has its
// register and memory writes suppressed (Valid_M stays set for the trap
// logic). When undefined, Overflow_M is always 0 and arithmetic wraps.
module ex_mem_alu_stage
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int REGW  = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       ALUControl,
  input  logic [WIDTH-1:0] RD1_E,
  input  logic [WIDTH-1:0] RD2_E,
  input  logic [WIDTH-1:0] SignImm_E,
  input  logic             ALUSrc_E,
  input  logic [1:0]       ForwardA_E,
  input  logic [1:0]       ForwardB_E,
  input  logic [WIDTH-1:0] Result_W,
  input  logic             RegWrite_E,
  input  logic             MemtoReg_E,
  input  logic             MemWrite_E,
  input  logic [REGW-1:0]  WriteReg_E,
  input  logic             Valid_E,
  input  logic             Stall_M,
  input  logic             Flush_M,
  output logic [WIDTH-1:0] ALUOut_M,
  output logic [WIDTH-1:0] WriteData_M,
  output logic [REGW-1:0]  WriteReg_M,
  output logic             RegWrite_M,
  output logic             MemtoReg_M,
  output logic             MemWrite_M,
  output logic             Zero_M,
  output logic             Valid_M,
  output logic             Overflow_M
);

`ifdef EX_OVERFLOW_TRAP_EN
  localparam logic TRAP_EN = 1'b1;
`else
  localparam logic TRAP_EN = 1'b0;
`endif

  logic [WIDTH-1:0] w_src_a;
  logic [WIDTH-1:0] w_fwd_b;
  logic [WIDTH-1:0] w_src_b;
  logic [WIDTH-1:0] w_alu_result;
  logic             w_alu_zero;
  logic             w_alu_ovf;
  logic             w_ovf_flag;
  logic             w_load_rw;
  logic             w_load_mw;

  logic [WIDTH-1:0] r_aluout_m;
  logic [WIDTH-1:0] r_wdata_m;
  logic [REGW-1:0]  r_wreg_m;
  logic             r_regwrite_m;
  logic             r_memtoreg_m;
  logic             r_memwrite_m;
  logic             r_zero_m;
  logic             r_valid_m;
  logic             r_ovf_m;

  // Operand A forwarding; the MEM source is the pre-edge registered result
  always_comb begin
    w_src_a = RD1_E;
    case (ForwardA_E)
      FWD_WB:  w_src_a = Result_W;
      FWD_MEM: w_src_a = r_aluout_m;
      default: w_src_a = RD1_E;
    endcase
  end

  // Operand B forwarding; this value is also the store data
  always_comb begin
    w_fwd_b = RD2_E;
    case (ForwardB_E)
      FWD_WB:  w_fwd_b = Result_W;
      FWD_MEM: w_fwd_b = r_aluout_m;
      default: w_fwd_b = RD2_E;
    endcase
  end

  assign w_src_b = ALUSrc_E ? SignImm_E : w_fwd_b;

  alu_core #(
    .WIDTH (WIDTH)
  ) u_alu_core (
    .i_a        (w_src_a),
    .i_b        (w_src_b),
    .i_ctrl     (ALUControl),
    .o_result   (w_alu_result),
    .o_zero     (w_alu_zero),
    .o_overflow (w_alu_ovf)
  );

  // Overflow only matters when the trap is built in; it then blocks writes
  assign w_ovf_flag = w_alu_ovf & TRAP_EN;
  assign w_load_rw  = RegWrite_E & Valid_E & ~w_ovf_flag;
  assign w_load_mw  = MemWrite_E & Valid_E & ~w_ovf_flag;

  // ---- EX/MEM register: reset > flush (bubble) > stall (hold) > load ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_aluout_m   <= '0;
      r_wdata_m    <= '0;
      r_wreg_m     <= '0;
      r_regwrite_m <= 1'b0;
      r_memtoreg_m <= 1'b0;
      r_memwrite_m <= 1'b0;
      r_zero_m     <= 1'b0;
      r_valid_m    <= 1'b0;
      r_ovf_m      <= 1'b0;
    end else if (Flush_M || !Stall_M) begin
      r_aluout_m   <= w_alu_result;
      r_wdata_m    <= w_fwd_b;
      r_wreg_m     <= WriteReg_E;
      r_memtoreg_m <= MemtoReg_E;
      r_zero_m     <= w_alu_zero;
      r_ovf_m      <= w_ovf_flag;
      r_regwrite_m <= Flush_M ? 1'b0 : w_load_rw;
      r_memwrite_m <= Flush_M ? 1'b0 : w_load_mw;
      r_valid_m    <= Flush_M ? 1'b0 : Valid_E;
    end
  end

  assign ALUOut_M    = r_aluout_m;
  assign WriteData_M = r_wdata_m;
  assign WriteReg_M  = r_wreg_m;
  assign RegWrite_M  = r_regwrite_m;
  assign MemtoReg_M  = r_memtoreg_m;
  assign MemWrite_M  = r_memwrite_m;
  assign Zero_M      = r_zero_m;
  assign Valid_M     = r_valid_m;
  assign Overflow_M  = r_ovf_m;

endmodule

// File: tb/tb_ex_mem_alu_stage.sv
// Self-checking bench for ex_mem_alu_stage: a table of directed ALU and
// forwarding vectors plus hand-written reset, stall and flush sequences.
module tb_ex_mem_alu_stage;

`ifdef EX_OVERFLOW_TRAP_EN
  localparam logic TRAP = 1'b1;
`else
  localparam logic TRAP = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic [2:0]  ALUControl;
  logic [31:0] RD1_E, RD2_E, SignImm_E, Result_W;
  logic        ALUSrc_E;
  logic [1:0]  ForwardA_E, ForwardB_E;
  logic        RegWrite_E, MemtoReg_E, MemWrite_E;
  logic [4:0]  WriteReg_E;
  logic        Valid_E, Stall_M, Flush_M;
  logic [31:0] ALUOut_M, WriteData_M;
  logic [4:0]  WriteReg_M;
  logic        RegWrite_M, MemtoReg_M, MemWrite_M, Zero_M, Valid_M, Overflow_M;

  int checks = 0;
  int errors = 0;

  ex_mem_alu_stage #(.WIDTH(32), .REGW(5)) dut (
    .clk(clk), .reset(reset), .ALUControl(ALUControl),
    .RD1_E(RD1_E), .RD2_E(RD2_E), .SignImm_E(SignImm_E), .ALUSrc_E(ALUSrc_E),
    .ForwardA_E(ForwardA_E), .ForwardB_E(ForwardB_E), .Result_W(Result_W),
    .RegWrite_E(RegWrite_E), .MemtoReg_E(MemtoReg_E), .MemWrite_E(MemWrite_E),
    .WriteReg_E(WriteReg_E), .Valid_E(Valid_E), .Stall_M(Stall_M), .Flush_M(Flush_M),
    .ALUOut_M(ALUOut_M), .WriteData_M(WriteData_M), .WriteReg_M(WriteReg_M),
    .RegWrite_M(RegWrite_M), .MemtoReg_M(MemtoReg_M), .MemWrite_M(MemWrite_M),
    .Zero_M(Zero_M), .Valid_M(Valid_M), .Overflow_M(Overflow_M)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] rd1, rd2, imm, resw;
    logic        alusrc;
    logic [1:0]  fa, fb;
    logic        rw, mtr, mw, vld;
    logic [4:0]  wreg;
    logic [31:0] e_out, e_wd;
    logic        e_zero, e_ovf;
  } vec_t;

  vec_t vecs[16];

  function automatic vec_t mkv(logic [2:0] op, logic [31:0] rd1, logic [31:0] rd2,
                               logic [31:0] imm, logic [31:0] resw, logic alusrc,
                               logic [1:0] fa, logic [1:0] fb, logic rw, logic mtr,
                               logic mw, logic vld, logic [4:0] wreg,
                               logic [31:0] e_out, logic [31:0] e_wd,
                               logic e_zero, logic e_ovf);
    vec_t v;
    v.op = op; v.rd1 = rd1; v.rd2 = rd2; v.imm = imm; v.resw = resw;
    v.alusrc = alusrc; v.fa = fa; v.fb = fb; v.rw = rw; v.mtr = mtr;
    v.mw = mw; v.vld = vld; v.wreg = wreg; v.e_out = e_out; v.e_wd = e_wd;
    v.e_zero = e_zero; v.e_ovf = e_ovf;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    ALUControl = v.op; RD1_E = v.rd1; RD2_E = v.rd2; SignImm_E = v.imm;
    Result_W = v.resw; ALUSrc_E = v.alusrc; ForwardA_E = v.fa; ForwardB_E = v.fb;
    RegWrite_E = v.rw; MemtoReg_E = v.mtr; MemWrite_E = v.mw; Valid_E = v.vld;
    WriteReg_E = v.wreg;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] all_out();
    return {ALUOut_M[15:0], WriteData_M[15:0], 8'(WriteReg_M),
            RegWrite_M, MemtoReg_M, MemWrite_M, Zero_M, Valid_M, Overflow_M, 2'b00,
            ALUOut_M[31:16] | WriteData_M[31:16]};
  endfunction

  initial begin
    vec_t v;
    logic eo, erw, emw;

    //             op      rd1           rd2           imm           resw          src fa     fb     rw mtr mw vld wreg  e_out         e_wd          z  ovf
    vecs[0]  = mkv(3'b000, 32'hF0F01234, 32'h0FF0FF00, 32'h0,        32'h0,        0, 2'b00, 2'b00, 1, 0, 0, 1, 5'd1,  32'h00F01200, 32'h0FF0FF00, 0, 0);
    vecs[1]  = mkv(3'b001, 32'hF0000000, 32'h0000000F, 32'h0,        32'h0,        0, 2'b00, 2'b00, 1, 0, 0, 1, 5'd2,  32'hF000000F, 32'h0000000F, 0, 0);
    vecs[2]  = mkv(3'b010, 32'h7FFFFFFF, 32'h00000001, 32'h0,        32'h0,        0, 2'b00, 2'b00, 1, 0, 0, 1, 5'd3,  32'h80000000, 32'h00000001, 0, 1);
    vecs[3]  = mkv(3'b110, 32'd10,       32'd3,        32'h0,        32'h0,        0, 2'b00, 2'b00, 0, 0, 1, 1, 5'd4,  32'd7,        32'd3,        0, 0);
    vecs[4]  = mkv(3'b110, 32'h80000000, 32'h00000001, 32'h0,        32'h0,        0, 2'b00, 2'b00, 0, 0, 1, 1, 5'd5,  32'h7FFFFFFF, 32'h00000001, 0, 1);
    vecs[5]  = mkv(3'b111, 32'h80000000, 32'h00000001, 32'h0,        32'h0,        0, 2'b00, 2'b00, 1, 0, 0, 1, 5'd6,  32'd1,        32'd1,        0, 0);
    vecs[6]  = mkv(3'b111, 32'd5,        32'd5,        32'h0,        32'h0,        0, 2'b00, 2'b00, 1, 1, 0, 1, 5'd7,  32'd0,        32'd5,        1, 0);
    vecs[7]  = mkv(3'b111, 32'd1,        32'h80000000, 32'h0,        32'h0,        0, 2'b00, 2'b00, 1, 0, 0, 1, 5'd8,  32'd0,        32'h80000000, 1, 0);
    vecs[8]  = mkv(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,        32'h0,        0, 2'b00, 2'b00, 1, 0, 0, 1, 5'd9,  32'd0,        32'hFFFFFFFF, 1, 0);
    vecs[9]  = mkv(3'b100, 32'h12345678, 32'h1,        32'h0,        32'h0,        0, 2'b00, 2'b00, 1, 0, 0, 1, 5'd10, 32'd0,        32'h1,        1, 0);
    vecs[10] = mkv(3'b101, 32'h12345678, 32'h2,        32'h0,        32'h0,        0, 2'b00, 2'b00, 1, 0, 0, 1, 5'd11, 32'd0,        32'h2,        1, 0);
    vecs[11] = mkv(3'b010, 32'd8,        32'h55,       32'hFFFFFFFC, 32'h0,        1, 2'b00, 2'b00, 1, 0, 0, 1, 5'd12, 32'd4,        32'h55,       0, 0);
    vecs[12] = mkv(3'b010, 32'd8,        32'h55,       32'hFFFFFFFC, 32'h0,        1, 2'b00, 2'b00, 1, 0, 1, 0, 5'd13, 32'd4,        32'h55,       0, 0);
    vecs[13] = mkv(3'b010, 32'd8,        32'd8,        32'h0,        32'h0,        0, 2'b00, 2'b00, 1, 0, 0, 1, 5'd14, 32'h10,       32'd8,        0, 0);
    vecs[14] = mkv(3'b010, 32'hDEAD0000, 32'hBEEF0000, 32'h0,        32'h20,       0, 2'b10, 2'b01, 1, 0, 0, 1, 5'd15, 32'h30,       32'h20,       0, 0);
    vecs[15] = mkv(3'b110, 32'hDEAD0000, 32'hBEEF0000, 32'h0,        32'h5,        0, 2'b01, 2'b10, 1, 0, 0, 1, 5'd16, 32'hFFFFFFD5, 32'h30,       0, 0);

    reset = 1'b1; Stall_M = 1'b0; Flush_M = 1'b0;
    drive(vecs[0]);
    #2;
    check("reset_initial", all_out(), 64'h0);
    tick();
    check("reset_held_edge", all_out(), 64'h0);
    @(negedge clk);
    reset = 1'b0;

    // Table-driven vectors, one instruction per cycle, no stall/flush
    for (int i = 0; i < 16; i++) begin
      v = vecs[i];
      drive(v);
      tick();
      eo  = TRAP & v.e_ovf;
      erw = v.rw & v.vld & ~eo;
      emw = v.mw & v.vld & ~eo;
      check($sformatf("v%0d_aluout", i), 64'(ALUOut_M), 64'(v.e_out));
      check($sformatf("v%0d_wdata", i), 64'(WriteData_M), 64'(v.e_wd));
      check($sformatf("v%0d_wreg", i), 64'(WriteReg_M), 64'(v.wreg));
      check($sformatf("v%0d_flags", i),
            64'({Zero_M, Overflow_M, RegWrite_M, MemWrite_M, MemtoReg_M, Valid_M}),
            64'({v.e_zero, eo, erw, emw, v.mtr, v.vld}));
      @(negedge clk);
    end

    // Stall held 3 cycles: outputs constant, MEM forwarding keeps the held value
    drive(mkv(3'b010, 32'd1, 32'd2, 32'h0, 32'h0, 0, 2'b00, 2'b00, 1, 0, 1, 1, 5'd20, 32'd3, 32'd2, 0, 0));
    tick();
    check("stall_pre_load", 64'(ALUOut_M), 64'd3);
    @(negedge clk);
    Stall_M = 1'b1;
    drive(mkv(3'b010, 32'h0, 32'd4, 32'h0, 32'h0, 0, 2'b10, 2'b00, 0, 1, 0, 1, 5'd21, 32'd7, 32'd4, 0, 0));
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("stall%0d_outs", k),
            64'({ALUOut_M, WriteData_M[7:0], 3'(WriteReg_M), RegWrite_M, MemtoReg_M, MemWrite_M, Valid_M}),
            64'({32'd3, 8'd2, 3'(5'd20), 1'b1, 1'b0, 1'b1, 1'b1}));
    end
    @(negedge clk);
    Stall_M = 1'b0;
    tick();
    check("stall_release_fwd", 64'(ALUOut_M), 64'd7);
    check("stall_release_wreg", 64'(WriteReg_M), 64'd21);

    // Stall and flush together: flush wins, data loads, writes and valid drop
    @(negedge clk);
    Stall_M = 1'b1; Flush_M = 1'b1;
    drive(mkv(3'b010, 32'd2, 32'd2, 32'h0, 32'h0, 0, 2'b00, 2'b00, 1, 1, 1, 1, 5'd22, 32'd4, 32'd2, 0, 0));
    tick();
    check("flush_aluout", 64'(ALUOut_M), 64'd4);
    check("flush_ctrl", 64'({Valid_M, RegWrite_M, MemWrite_M, MemtoReg_M}), 64'(4'b0001));

    // Reset asserted mid-stall: outputs clear immediately, first edge after release loads
    @(negedge clk);
    Flush_M = 1'b0; Stall_M = 1'b0;
    drive(mkv(3'b001, 32'h00F0, 32'h0F00, 32'h0, 32'h0, 0, 2'b00, 2'b00, 1, 0, 1, 1, 5'd23, 32'h0FF0, 32'h0F00, 0, 0));
    tick();
    check("mid_load", 64'(ALUOut_M), 64'h0FF0);
    Stall_M = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_clear", all_out(), 64'h0);
    tick();
    check("reset_held_stall", all_out(), 64'h0);
    @(negedge clk);
    reset = 1'b0; Stall_M = 1'b0;
    drive(mkv(3'b110, 32'd9, 32'd9, 32'h0, 32'h0, 0, 2'b00, 2'b00, 1, 0, 0, 1, 5'd24, 32'd0, 32'd9, 1, 0));
    #1;
    check("reset_release_noedge", all_out(), 64'h0);
    tick();
    check("post_reset_load",
          64'({ALUOut_M, 8'(WriteReg_M), Zero_M, Valid_M, RegWrite_M}),
          64'({32'd0, 8'd24, 1'b1, 1'b1, 1'b1}));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
